axil_rr_arbiter: RTL and testbench

AXIL_RR_ARBITER -- requirements
Module: axil_rr_arbiter

---
 rtl/axil_arb_pkg.sv | 21 ++
 rtl/axil_rr_arbiter_rr_grant.sv | 21 ++
 rtl/axil_rr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_axil_rr_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI-lite round-robin arbiter.
// Holds the FSM state encoding, default bus widths and AXI response codes.
package axil_arb_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } arb_state_e;

endpackage

// File: rtl/axil_rr_arbiter_rr_grant.sv
// Two-way round-robin picker: the requester that did not win last time has
// priority, falling back to the previous winner when it is the only one asking.
module rr_grant (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    logic other;

    always_comb begin
        other       = ~last_grant;
        grant       = last_grant;
        grant_valid = |eligible;
        if (eligible[other]) begin
            grant = other;
        end
    end

endmodule

// File: rtl/axil_rr_arbiter.sv
// Arbitrates two AXI-lite requesters onto one downstream AXI-lite master port,
// one transaction at a time, alternating grants and preferring writes.
module axil_rr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic [1:0]                           s_arvalid,
    output logic [1:0]                           s_arready,
    input  logic [1:0][ADDR_WIDTH-1:0]           s_araddr,
    output logic [1:0]                           s_rvalid,
    input  logic [1:0]                           s_rready,
    output logic [DATA_WIDTH-1:0]                s_rdata,
    output logic [1:0]                           s_rresp,

    input  logic [1:0]                           s_awvalid,
    output logic [1:0]                           s_awready,
    input  logic [1:0][ADDR_WIDTH-1:0]           s_awaddr,
    input  logic [1:0]                           s_wvalid,
    output logic [1:0]                           s_wready,
    input  logic [1:0][DATA_WIDTH-1:0]           s_wdata,
    input  logic [1:0][DATA_WIDTH/8-1:0]         s_wstrb,
    output logic [1:0]                           s_bvalid,
    input  logic [1:0]                           s_bready,
    output logic [1:0]                           s_bresp,

    output logic                                 m_axil_arvalid,
    input  logic                                 m_axil_arready,
    output logic [ADDR_WIDTH-1:0]                m_axil_araddr,
    input  logic                                 m_axil_rvalid,
    output logic                                 m_axil_rready,
    input  logic [DATA_WIDTH-1:0]                m_axil_rdata,
    input  logic [1:0]                           m_axil_rresp,

    output logic                                 m_axil_awvalid,
    input  logic                                 m_axil_awready,
    output logic [ADDR_WIDTH-1:0]                m_axil_awaddr,
    output logic                                 m_axil_wvalid,
    input  logic                                 m_axil_wready,
    output logic [DATA_WIDTH-1:0]                m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]              m_axil_wstrb,
    input  logic                                 m_axil_bvalid,
    output logic                                 m_axil_bready,
    input  logic [1:0]                           m_axil_bresp
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [1:0] write_elig;
    logic [1:0] eligible;
    logic       pick;
    logic       pick_valid;

    assign write_elig = s_awvalid & s_wvalid;
    assign eligible   = s_arvalid | write_elig;

    rr_grant u_rr_grant (
        .eligible    (eligible),
        .last_grant  (last_grant_q),
        .grant       (pick),
        .grant_valid (pick_valid)
    );

    // Payloads follow the registered grant; only the handshakes are gated by state.
    assign m_axil_araddr = s_araddr[grant_q];
    assign m_axil_awaddr = s_awaddr[grant_q];
    assign m_axil_wdata  = s_wdata[grant_q];
    assign m_axil_wstrb  = s_wstrb[grant_q];
    assign s_rdata       = m_axil_rdata;
    assign s_rresp       = m_axil_rresp;
    assign s_bresp       = m_axil_bresp;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        s_arready      = 2'b00;
        s_rvalid       = 2'b00;
        s_awready      = 2'b00;
        s_wready       = 2'b00;
        s_bvalid       = 2'b00;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    state_d = write_elig[pick] ? ST_AW_W : ST_AR;
                end
            end
            ST_AR: begin
                m_axil_arvalid     = 1'b1;
                s_arready[grant_q] = m_axil_arready;
                if (m_axil_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                s_rvalid[grant_q] = m_axil_rvalid;
                m_axil_rready     = s_rready[grant_q];
                if (m_axil_rvalid && s_rready[grant_q]) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            ST_AW_W: begin
                // Each channel stops driving once its own handshake has happened.
                m_axil_awvalid     = ~aw_done_q;
                s_awready[grant_q] = m_axil_awready & ~aw_done_q;
                m_axil_wvalid      = ~w_done_q;
                s_wready[grant_q]  = m_axil_wready & ~w_done_q;
                aw_done_d          = aw_done_q | m_axil_awready;
                w_done_d           = w_done_q | m_axil_wready;
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_B: begin
                s_bvalid[grant_q] = m_axil_bvalid;
                m_axil_bready     = s_bready[grant_q];
                if (m_axil_bvalid && s_bready[grant_q]) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first contended round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench for axil_rr_arbiter: reads, contention, split writes,
// read/write priority, mid-transaction reset and read backpressure.
module tb_axil_rr_arbiter;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 64;

    logic                             clk;
    logic                             rst;
    logic [1:0]                       s_arvalid;
    logic [1:0]                       s_arready;
    logic [1:0][ADDR_WIDTH-1:0]       s_araddr;
    logic [1:0]                       s_rvalid;
    logic [1:0]                       s_rready;
    logic [DATA_WIDTH-1:0]            s_rdata;
    logic [1:0]                       s_rresp;
    logic [1:0]                       s_awvalid;
    logic [1:0]                       s_awready;
    logic [1:0][ADDR_WIDTH-1:0]       s_awaddr;
    logic [1:0]                       s_wvalid;
    logic [1:0]                       s_wready;
    logic [1:0][DATA_WIDTH-1:0]       s_wdata;
    logic [1:0][DATA_WIDTH/8-1:0]     s_wstrb;
    logic [1:0]                       s_bvalid;
    logic [1:0]                       s_bready;
    logic [1:0]                       s_bresp;
    logic                             m_axil_arvalid;
    logic                             m_axil_arready;
    logic [ADDR_WIDTH-1:0]            m_axil_araddr;
    logic                             m_axil_rvalid;
    logic                             m_axil_rready;
    logic [DATA_WIDTH-1:0]            m_axil_rdata;
    logic [1:0]                       m_axil_rresp;
    logic                             m_axil_awvalid;
    logic                             m_axil_awready;
    logic [ADDR_WIDTH-1:0]            m_axil_awaddr;
    logic                             m_axil_wvalid;
    logic                             m_axil_wready;
    logic [DATA_WIDTH-1:0]            m_axil_wdata;
    logic [DATA_WIDTH/8-1:0]          m_axil_wstrb;
    logic                             m_axil_bvalid;
    logic                             m_axil_bready;
    logic [1:0]                       m_axil_bresp;

    int assertCount = 0;
    int failCount   = 0;

    axil_rr_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_arvalid      (s_arvalid),
        .s_arready      (s_arready),
        .s_araddr       (s_araddr),
        .s_rvalid       (s_rvalid),
        .s_rready       (s_rready),
        .s_rdata        (s_rdata),
        .s_rresp        (s_rresp),
        .s_awvalid      (s_awvalid),
        .s_awready      (s_awready),
        .s_awaddr       (s_awaddr),
        .s_wvalid       (s_wvalid),
        .s_wready       (s_wready),
        .s_wdata        (s_wdata),
        .s_wstrb        (s_wstrb),
        .s_bvalid       (s_bvalid),
        .s_bready       (s_bready),
        .s_bresp        (s_bresp),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready),
        .m_axil_bresp   (m_axil_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        s_arvalid      = 2'b00;
        s_araddr       = '0;
        s_rready       = 2'b00;
        s_awvalid      = 2'b00;
        s_awaddr       = '0;
        s_wvalid       = 2'b00;
        s_wdata        = '0;
        s_wstrb        = '0;
        s_bready       = 2'b00;
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b0;
        m_axil_rdata   = '0;
        m_axil_rresp   = 2'b00;
        m_axil_awready = 1'b0;
        m_axil_wready  = 1'b0;
        m_axil_bvalid  = 1'b0;
        m_axil_bresp   = 2'b00;
    endtask

    logic [1:0] expGrant;

    initial begin
        rst = 1'b0;
        clearInputs();

        // Reset state
        #1;
        checkOutput("rst_m_arvalid", 64'(m_axil_arvalid), 64'd0);
        checkOutput("rst_m_awvalid", 64'(m_axil_awvalid), 64'd0);
        checkOutput("rst_m_wvalid", 64'(m_axil_wvalid), 64'd0);
        checkOutput("rst_s_arready", 64'(s_arready), 64'd0);
        checkOutput("rst_s_bvalid", 64'(s_bvalid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single read from requester 0
        $display("[TB] single read");
        s_arvalid   = 2'b01;
        s_araddr[0] = 32'h8000_0010;
        #1;
        checkOutput("rd_arb_cycle_arvalid", 64'(m_axil_arvalid), 64'd0);
        applyStimulus(1);
        checkOutput("rd_arvalid", 64'(m_axil_arvalid), 64'd1);
        checkOutput("rd_araddr", 64'(m_axil_araddr), 64'h8000_0010);
        checkOutput("rd_s_arready_wait", 64'(s_arready), 64'd0);
        m_axil_arready = 1'b1;
        #1;
        checkOutput("rd_s_arready", 64'(s_arready), 64'b01);
        applyStimulus(1);
        s_arvalid      = 2'b00;
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b1;
        m_axil_rdata   = 64'h1122_3344_5566_7788;
        s_rready       = 2'b01;
        #1;
        checkOutput("rd_s_rvalid", 64'(s_rvalid), 64'b01);
        checkOutput("rd_s_rdata", s_rdata, 64'h1122_3344_5566_7788);
        checkOutput("rd_m_rready", 64'(m_axil_rready), 64'd1);
        applyStimulus(1);
        clearInputs();
        #1;
        checkOutput("rd_done_s_rvalid", 64'(s_rvalid), 64'd0);

        // Continuous reads from both requesters alternate grants
        $display("[TB] contention");
        s_arvalid      = 2'b11;
        s_araddr[0]    = 32'h0000_0100;
        s_araddr[1]    = 32'h0000_0200;
        m_axil_arready = 1'b1;
        m_axil_rvalid  = 1'b1;
        s_rready       = 2'b11;
        expGrant       = 2'b10;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("cont_arready_%0d", i), 64'(s_arready), 64'(expGrant));
            applyStimulus(1);
            checkOutput($sformatf("cont_rvalid_%0d", i), 64'(s_rvalid), 64'(expGrant));
            applyStimulus(1);
            expGrant = {expGrant[0], expGrant[1]};
        end
        clearInputs();

        // Split write from requester 1, wready three cycles after awready
        $display("[TB] split write");
        m_axil_bvalid = 1'b1;
        #1;
        checkOutput("idle_stale_bready", 64'(m_axil_bready), 64'd0);
        checkOutput("idle_stale_bvalid", 64'(s_bvalid), 64'd0);
        m_axil_bvalid = 1'b0;
        s_awvalid   = 2'b10;
        s_wvalid    = 2'b10;
        s_awaddr[1] = 32'h0000_0040;
        s_wdata[1]  = 64'hDEAD_BEEF_CAFE_F00D;
        s_wstrb[1]  = 8'h0F;
        applyStimulus(1);
        checkOutput("wr_awvalid", 64'(m_axil_awvalid), 64'd1);
        checkOutput("wr_wvalid", 64'(m_axil_wvalid), 64'd1);
        checkOutput("wr_awaddr", 64'(m_axil_awaddr), 64'h40);
        checkOutput("wr_wstrb", 64'(m_axil_wstrb), 64'h0F);
        checkOutput("wr_wdata", m_axil_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        m_axil_awready = 1'b1;
        #1;
        checkOutput("wr_s_awready", 64'(s_awready), 64'b10);
        checkOutput("wr_s_wready_wait", 64'(s_wready), 64'b00);
        applyStimulus(1);
        m_axil_awready = 1'b0;
        s_awvalid      = 2'b00;
        #1;
        checkOutput("wr_aw_dropped", 64'(m_axil_awvalid), 64'd0);
        checkOutput("wr_w_held", 64'(m_axil_wvalid), 64'd1);
        applyStimulus(2);
        checkOutput("wr_w_still_held", 64'(m_axil_wvalid), 64'd1);
        m_axil_wready = 1'b1;
        #1;
        checkOutput("wr_s_wready", 64'(s_wready), 64'b10);
        applyStimulus(1);
        m_axil_wready = 1'b0;
        s_wvalid      = 2'b00;
        m_axil_bvalid = 1'b1;
        m_axil_bresp  = 2'b00;
        s_bready      = 2'b11;
        #1;
        checkOutput("wr_s_bvalid", 64'(s_bvalid), 64'b10);
        checkOutput("wr_m_bready", 64'(m_axil_bready), 64'd1);
        checkOutput("wr_s_bresp", 64'(s_bresp), 64'd0);
        applyStimulus(1);
        clearInputs();
        #1;
        checkOutput("wr_done_bvalid", 64'(s_bvalid), 64'd0);

        // Requester 0 read and write together: write goes first
        $display("[TB] write priority");
        s_arvalid   = 2'b01;
        s_araddr[0] = 32'h0000_1000;
        s_awvalid   = 2'b01;
        s_wvalid    = 2'b01;
        s_awaddr[0] = 32'h0000_2000;
        s_wdata[0]  = 64'h0123_4567_89AB_CDEF;
        s_wstrb[0]  = 8'hFF;
        applyStimulus(1);
        checkOutput("rw_awvalid_first", 64'(m_axil_awvalid), 64'd1);
        checkOutput("rw_arvalid_not_yet", 64'(m_axil_arvalid), 64'd0);
        checkOutput("rw_awaddr", 64'(m_axil_awaddr), 64'h2000);
        m_axil_awready = 1'b1;
        m_axil_wready  = 1'b1;
        #1;
        checkOutput("rw_s_awready", 64'(s_awready), 64'b01);
        checkOutput("rw_s_wready", 64'(s_wready), 64'b01);
        applyStimulus(1);
        s_awvalid      = 2'b00;
        s_wvalid       = 2'b00;
        m_axil_awready = 1'b0;
        m_axil_wready  = 1'b0;
        m_axil_bvalid  = 1'b1;
        s_bready       = 2'b01;
        #1;
        checkOutput("rw_s_bvalid", 64'(s_bvalid), 64'b01);
        applyStimulus(1);
        m_axil_bvalid = 1'b0;
        s_bready      = 2'b00;
        applyStimulus(1);
        checkOutput("rw_arvalid_after", 64'(m_axil_arvalid), 64'd1);
        checkOutput("rw_araddr", 64'(m_axil_araddr), 64'h1000);
        m_axil_arready = 1'b1;
        #1;
        checkOutput("rw_s_arready", 64'(s_arready), 64'b01);
        applyStimulus(1);

        // Reset asserted in R with rvalid pending
        $display("[TB] reset in R");
        s_arvalid      = 2'b00;
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b1;
        m_axil_rdata   = 64'hFFFF_0000_FFFF_0000;
        s_rready       = 2'b11;
        #1;
        checkOutput("rr_pre_s_rvalid", 64'(s_rvalid), 64'b01);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rr_async_s_rvalid", 64'(s_rvalid), 64'd0);
        checkOutput("rr_async_m_rready", 64'(m_axil_rready), 64'd0);
        checkOutput("rr_async_m_arvalid", 64'(m_axil_arvalid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rr_stale_m_rready", 64'(m_axil_rready), 64'd0);
        applyStimulus(1);
        checkOutput("rr_stale_s_rvalid", 64'(s_rvalid), 64'd0);
        checkOutput("rr_stale_m_rready2", 64'(m_axil_rready), 64'd0);
        clearInputs();

        // Backpressure on requester 1 read data
        $display("[TB] backpressure");
        s_arvalid      = 2'b10;
        s_araddr[1]    = 32'h0000_3000;
        m_axil_arready = 1'b1;
        applyStimulus(1);
        checkOutput("bp_s_arready", 64'(s_arready), 64'b10);
        checkOutput("bp_araddr", 64'(m_axil_araddr), 64'h3000);
        applyStimulus(1);
        s_arvalid      = 2'b01;
        s_araddr[0]    = 32'h0000_4000;
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b1;
        m_axil_rdata   = 64'hA5A5_A5A5_5A5A_5A5A;
        s_rready       = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp_m_rready_%0d", i), 64'(m_axil_rready), 64'd0);
            checkOutput($sformatf("bp_s_rvalid_%0d", i), 64'(s_rvalid), 64'b10);
            checkOutput($sformatf("bp_rdata_%0d", i), s_rdata, 64'hA5A5_A5A5_5A5A_5A5A);
            checkOutput($sformatf("bp_no_grant_%0d", i), 64'(m_axil_arvalid), 64'd0);
            applyStimulus(1);
        end
        s_rready = 2'b10;
        #1;
        checkOutput("bp_m_rready_release", 64'(m_axil_rready), 64'd1);
        applyStimulus(1);
        m_axil_rvalid = 1'b0;
        s_rready      = 2'b00;
        applyStimulus(1);
        checkOutput("bp_next_arvalid", 64'(m_axil_arvalid), 64'd1);
        checkOutput("bp_next_araddr", 64'(m_axil_araddr), 64'h4000);
        checkOutput("bp_next_s_arready", 64'(s_arready), 64'b00);
        clearInputs();
        applyStimulus(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
